// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg
// Shared definitions for the approximate multiplier pipeline.
//   Q_LL/Q_LH/Q_HL/Q_HH : quadrant indices into the mode vector and quadrant arrays
//   quad_mode_t         : per-quadrant approximation enables (1 = truncate)
//   trunc_mask()        : mask with bits [width-1:trunc] set and bits [trunc-1:0] cleared
package approx_mul_pkg;

  localparam int Q_LL = 0;
  localparam int Q_LH = 1;
  localparam int Q_HL = 2;
  localparam int Q_HH = 3;

  typedef logic [3:0] quad_mode_t;

  // Returned as 64 bits so callers of any product width up to 64 can slice it.
  function automatic logic [63:0] trunc_mask(input int width, input int trunc);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i < width) && (i >= trunc)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_quad_mul.sv
// approx_quad_mul
// One combinational H x H quadrant multiplier. When approx is set, the low
// TRUNC bits of the exact product are forced to zero.
// Ports:
//   x, y   : H-bit unsigned operand halves
//   approx : 1 = truncated product, 0 = exact product
//   p      : 2H-bit product
module approx_quad_mul
  import approx_mul_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  localparam logic [63:0] MASK64 = trunc_mask(2 * H, TRUNC);

  logic [2*H-1:0] prod;

  // Zero-extend before multiplying so the full 2H-bit product is kept.
  assign prod = {{H{1'b0}}, x} * {{H{1'b0}}, y};
  assign p    = approx ? (prod & MASK64[2*H-1:0]) : prod;

endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe
// Three-stage pipelined WIDTH x WIDTH unsigned approximate multiplier with a
// valid/ready stream interface. Each of the four half-width quadrant products
// may be truncated independently according to the mode sampled with the operands.
//   S1: register a, b, mode
//   S2: register the four quadrant products
//   S3: register the recombined product
// All stages advance together whenever the output is empty or being taken.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_ready is combinational)
//   in_a, in_b           : unsigned operands
//   in_mode              : approx enables [3]=HH [2]=HL [1]=LH [0]=LL
//   out_valid/out_ready  : result handshake
//   out_prod             : 2*WIDTH-bit product
//   out_err              : exact product minus out_prod (only when
//                          APPROX_MUL_ERRMON_EN is defined)
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [3:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
`ifdef APPROX_MUL_ERRMON_EN
  ,
  output logic [2*WIDTH-1:0] out_err
`endif
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int QW = 2 * H;

  logic adv;

  // Stage 1
  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] b1_q;
  quad_mode_t       mode1_q;

  // Stage 2
  logic             v2_q;
  logic [H-1:0]     a_half[2];
  logic [H-1:0]     b_half[2];
  logic [QW-1:0]    quad_d[4];
  logic [QW-1:0]    quad_q[4];

  // Stage 3
  logic             v3_q;
  logic [PW-1:0]    sum_d;
  logic [PW-1:0]    prod3_q;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_prod  = prod3_q;

  // Data registers load only with a valid transaction, so bubbles never
  // disturb held values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      mode1_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q    <= in_a;
        b1_q    <= in_b;
        mode1_q <= in_mode;
      end
    end
  end

  // Index 0 selects the low half, index 1 the high half; this matches the
  // quadrant numbering (bit 1 picks the a half, bit 0 the b half).
  assign a_half[0] = a1_q[H-1:0];
  assign a_half[1] = a1_q[WIDTH-1:H];
  assign b_half[0] = b1_q[H-1:0];
  assign b_half[1] = b1_q[WIDTH-1:H];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_quad
      approx_quad_mul #(
        .H    (H),
        .TRUNC(TRUNC)
      ) u_quad (
        .x     (a_half[gi/2]),
        .y     (b_half[gi%2]),
        .approx(mode1_q[gi]),
        .p     (quad_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q <= 1'b0;
      for (int i = 0; i < 4; i++) quad_q[i] <= '0;
    end else if (adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        for (int i = 0; i < 4; i++) quad_q[i] <= quad_d[i];
      end
    end
  end

  assign sum_d = (PW'(quad_q[Q_HH]) << WIDTH)
               + ((PW'(quad_q[Q_HL]) + PW'(quad_q[Q_LH])) << H)
               + PW'(quad_q[Q_LL]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q    <= 1'b0;
      prod3_q <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      if (v2_q) prod3_q <= sum_d;
    end
  end

`ifdef APPROX_MUL_ERRMON_EN
  // Exact product travels alongside the approximate one; the difference is
  // taken in S3 so out_err lines up with out_prod.
  logic [PW-1:0] exact2_q;
  logic [PW-1:0] err3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exact2_q <= '0;
      err3_q   <= '0;
    end else if (adv) begin
      if (v1_q) exact2_q <= PW'(a1_q) * PW'(b1_q);
      if (v2_q) err3_q   <= exact2_q - sum_d;
    end
  end

  assign out_err = err3_q;
`else
  // Error monitor disabled: no exact-product path is built.
`endif

endmodule
